zaman_raporlayici: RTL and testbench
====================================

Name: zaman_raporlayici

Overview:
- Downstream consumer of the clock/calendar core's time registers (saat, dakika, saniye, gun, ay, yil).
- On request, or periodically, snapshots the time, converts it to ASCII and streams the 21-byte frame "YYYY-MM-DD HH:MM:SS\r\n" into the existing uart_tx byte interface (uart_tx_en / uart_tx_data / uart_tx_busy).
- Replaces ad-hoc $display reporting with a synthesizable serial time report.

Parameters:
- PERIYOT_CYC, 100000000: periodic report interval in CLK cycles. Legal range is 2 or more.
- CERCEVE_UZUNLUGU, 21: bytes per frame. Fixed; not to be overridden.

Ports:
- CLK  input  1  system clock
- reset  input  1  synchronous, active-high reset
- baslat  input  1  one-cycle report request
- periyodik_en  input  1  enables the periodic report timer
- saat  input  5  hour, 0-23 nominal
- dakika  input  6  minute, 0-59 nominal
- saniye  input  6  second, 0-59 nominal
- gun  input  5  day, 1-31 nominal
- ay  input  4  month, 1-12 nominal
- yil  input  12  year, 0-4095
- uart_tx_busy  input  1  transmitter busy
- uart_tx_en  output  1  one-cycle byte strobe to transmitter
- uart_tx_data  output  8  byte to transmit
- mesgul  output  1  frame in progress
- tamamlandi  output  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Clock and reset
  - Single clock CLK; reset is synchronous and active-high.
  - While reset=1: state=BOSTA, uart_tx_en=0, uart_tx_data=0, mesgul=0, tamamlandi=0, pending flag=0, period counter=0.
- Request sources
  - istek = baslat OR (period counter tick).
  - The period counter runs 0..PERIYOT_CYC-1 while periyodik_en=1. It ticks on reaching PERIYOT_CYC-1, then wraps to 0.
  - When periyodik_en=0 the counter is held at 0.
- Pending request
  - An istek arriving while mesgul=1 sets a single pending flag. Further requests are coalesced into that flag, not counted.
  - The pending flag is serviced immediately after tamamlandi.
- FSM states
  - BOSTA: on istek or pending, register all six time inputs (snapshot), clear pending, go to DONUSTUR. mesgul=1 from the next cycle.
  - DONUSTUR: one cycle. Register BCD digits from the snapshot. Byte index=0. Go to GONDER.
  - GONDER: if uart_tx_busy=0, drive uart_tx_data=frame[index], pulse uart_tx_en for exactly one cycle, go to KORUMA. Otherwise hold.
  - KORUMA: one cycle in which uart_tx_busy is ignored (covers transmitter busy-assert latency). Go to BEKLE.
  - BEKLE: when uart_tx_busy=0: if index=20, pulse tamamlandi and go to BOSTA (mesgul=0); else increment index and go to GONDER.
- Latency
  - baslat at cycle 0 with busy=0 gives the first uart_tx_en at cycle 3.
- Frame layout (indices 0-20)
  - 0-3: yil digits, thousands first.
  - 4: '-' (0x2D). 5-6: ay. 7: '-'. 8-9: gun.
  - 10: ' ' (0x20). 11-12: saat. 13: ':' (0x3A). 14-15: dakika. 16: ':'. 17-18: saniye.
  - 19: 0x0D. 20: 0x0A.
  - Digits are ASCII 0x30+BCD.
- Arithmetic and widths
  - 2-digit fields print value mod 100 with a leading zero. Out-of-range inputs (e.g. saat=27, dakika=63) print their literal decimal value with no clamping.
  - yil prints 4 digits with leading zeros (e.g. 7 → "0007").
- Stability
  - Input changes after the snapshot do not affect the frame in progress.
- Reset mid-frame
  - Abort on the next edge: uart_tx_en=0 and no tamamlandi. A byte already handed to uart_tx is that module's concern.
- Simultaneous events
  - baslat and period tick in the same cycle produce one request.
  - istek in the same cycle as tamamlandi sets pending, giving a back-to-back frame.

Decomposition:
- Shared package zaman_pkg holds:
  - state enum: BOSTA, DONUSTUR, GONDER, KORUMA, BEKLE
  - ASCII constants: TIRE, BOSLUK, IKI_NOKTA, CR, LF, ASCII_SIFIR
  - CERCEVE_UZUNLUGU
- One sub-module, bcd_donusturucu: combinational double-dabble, parameterised input width (12 → 4 digits, 6 → 2 digits). Instantiated per field, with outputs registered in DONUSTUR.

Test Plan:
- Nominal frame: yil=2024, ay=7, gun=30, saat=18, dakika=30, saniye=5; baslat; a uart_tx model asserts busy for 10 cycles per byte → bytes "2024-07-30 18:30:05\r\n"; one tamamlandi; exactly 21 uart_tx_en pulses.
- Leading zeros: yil=7, ay=1, gun=1, saat=0, dakika=0, saniye=9 → "0007-01-01 00:00:09\r\n".
- Snapshot hold: change saat 18→19 at byte 5 → frame still shows "18".
- Pending coalescing: three baslat pulses during a frame → exactly one further frame, starting right after tamamlandi.
- Periodic mode: PERIYOT_CYC=500, periyodik_en=1, fast busy model → frames start every 500 cycles. Dropping periyodik_en stops new frames and the counter reads 0.
- Reset mid-frame: reset at byte 10 → uart_tx_en=0 and mesgul=0 after the next edge, no tamamlandi; a subsequent baslat sends a full frame from byte 0.

Source files
------------

// File: rtl/zaman_pkg.sv
// Shared types and ASCII constants for the serial time reporter.
package zaman_pkg;

    typedef enum logic [2:0] {
        BOSTA,
        DONUSTUR,
        GONDER,
        KORUMA,
        BEKLE
    } durum_t;

    localparam int unsigned CERCEVE_UZUNLUGU = 21;

    localparam logic [7:0] TIRE        = 8'h2D;
    localparam logic [7:0] BOSLUK      = 8'h20;
    localparam logic [7:0] IKI_NOKTA   = 8'h3A;
    localparam logic [7:0] CR          = 8'h0D;
    localparam logic [7:0] LF          = 8'h0A;
    localparam logic [7:0] ASCII_SIFIR = 8'h30;

    function automatic logic [7:0] rakam_ascii(input logic [3:0] rakam);
        return ASCII_SIFIR + 8'(rakam);
    endfunction

endpackage

// File: rtl/bcd_donusturucu.sv
// Combinational double-dabble binary to packed-BCD converter.
module bcd_donusturucu #(
    parameter int unsigned GIRIS_W = 12,
    parameter int unsigned BASAMAK = 4
) (
    input  logic [GIRIS_W-1:0]   ikili,
    output logic [4*BASAMAK-1:0] bcd
);

    localparam int unsigned KAY_W = GIRIS_W + 4*BASAMAK;

    logic [KAY_W-1:0] kay;

    // Adjust every digit >= 5 before each shift so the carry lands in the next decade.
    always_comb begin
        kay = {{(4*BASAMAK){1'b0}}, ikili};
        for (int i = 0; i < int'(GIRIS_W); i++) begin
            for (int d = 0; d < int'(BASAMAK); d++) begin
                if (kay[GIRIS_W+4*d +: 4] >= 4'd5) begin
                    kay[GIRIS_W+4*d +: 4] = kay[GIRIS_W+4*d +: 4] + 4'd3;
                end
            end
            kay = kay << 1;
        end
        bcd = kay[GIRIS_W +: 4*BASAMAK];
    end

endmodule

// File: rtl/zaman_raporlayici.sv
// Snapshots the calendar time on request or periodically and streams
// "YYYY-MM-DD HH:MM:SS\r\n" into the uart_tx byte interface.
module zaman_raporlayici
    import zaman_pkg::*;
#(
    parameter int unsigned PERIYOT_CYC = 100000000
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        baslat,
    input  logic        periyodik_en,
    input  logic [4:0]  saat,
    input  logic [5:0]  dakika,
    input  logic [5:0]  saniye,
    input  logic [4:0]  gun,
    input  logic [3:0]  ay,
    input  logic [11:0] yil,
    input  logic        uart_tx_busy,
    output logic        uart_tx_en,
    output logic [7:0]  uart_tx_data,
    output logic        mesgul,
    output logic        tamamlandi
);

    localparam int unsigned SAYAC_W  = $clog2(PERIYOT_CYC);
    localparam int unsigned INDEKS_W = $clog2(CERCEVE_UZUNLUGU);
    localparam logic [INDEKS_W-1:0] SON_INDEKS = INDEKS_W'(CERCEVE_UZUNLUGU - 1);
    localparam logic [SAYAC_W-1:0]  SON_SAYAC  = SAYAC_W'(PERIYOT_CYC - 1);

    durum_t              durum, durum_n;
    logic [SAYAC_W-1:0]  sayac;
    logic                tik_c, istek_c, yakala_c;
    logic                bekleyen, bekleyen_n;
    logic [INDEKS_W-1:0] indeks, indeks_n;
    logic                uart_tx_en_n, mesgul_n, tamamlandi_n;
    logic [7:0]          uart_tx_data_n, bayt_c;

    logic [11:0] s_yil;
    logic [3:0]  s_ay;
    logic [4:0]  s_gun, s_saat;
    logic [5:0]  s_dakika, s_saniye;

    logic [15:0] yil_bcd_c, b_yil;
    logic [7:0]  ay_bcd_c, gun_bcd_c, saat_bcd_c, dakika_bcd_c, saniye_bcd_c;
    logic [7:0]  b_ay, b_gun, b_saat, b_dakika, b_saniye;

    assign tik_c   = periyodik_en && (sayac == SON_SAYAC);
    assign istek_c = baslat || tik_c;

    // Period counter: free-runs 0..PERIYOT_CYC-1 while enabled, parked at 0 otherwise.
    always_ff @(posedge CLK) begin
        if (reset || !periyodik_en || tik_c) begin
            sayac <= '0;
        end else begin
            sayac <= sayac + SAYAC_W'(1);
        end
    end

    bcd_donusturucu #(.GIRIS_W(12), .BASAMAK(4)) u_yil    (.ikili(s_yil),       .bcd(yil_bcd_c));
    bcd_donusturucu #(.GIRIS_W(6),  .BASAMAK(2)) u_ay     (.ikili(6'(s_ay)),    .bcd(ay_bcd_c));
    bcd_donusturucu #(.GIRIS_W(6),  .BASAMAK(2)) u_gun    (.ikili(6'(s_gun)),   .bcd(gun_bcd_c));
    bcd_donusturucu #(.GIRIS_W(6),  .BASAMAK(2)) u_saat   (.ikili(6'(s_saat)),  .bcd(saat_bcd_c));
    bcd_donusturucu #(.GIRIS_W(6),  .BASAMAK(2)) u_dakika (.ikili(s_dakika),    .bcd(dakika_bcd_c));
    bcd_donusturucu #(.GIRIS_W(6),  .BASAMAK(2)) u_saniye (.ikili(s_saniye),    .bcd(saniye_bcd_c));

    // Snapshot is frozen for the whole frame; digits are registered once per frame.
    always_ff @(posedge CLK) begin
        if (reset) begin
            s_yil    <= '0;
            s_ay     <= '0;
            s_gun    <= '0;
            s_saat   <= '0;
            s_dakika <= '0;
            s_saniye <= '0;
            b_yil    <= '0;
            b_ay     <= '0;
            b_gun    <= '0;
            b_saat   <= '0;
            b_dakika <= '0;
            b_saniye <= '0;
        end else begin
            if (yakala_c) begin
                s_yil    <= yil;
                s_ay     <= ay;
                s_gun    <= gun;
                s_saat   <= saat;
                s_dakika <= dakika;
                s_saniye <= saniye;
            end
            if (durum == DONUSTUR) begin
                b_yil    <= yil_bcd_c;
                b_ay     <= ay_bcd_c;
                b_gun    <= gun_bcd_c;
                b_saat   <= saat_bcd_c;
                b_dakika <= dakika_bcd_c;
                b_saniye <= saniye_bcd_c;
            end
        end
    end

    always_comb begin
        bayt_c = LF;
        case (indeks)
            5'd0:    bayt_c = rakam_ascii(b_yil[15:12]);
            5'd1:    bayt_c = rakam_ascii(b_yil[11:8]);
            5'd2:    bayt_c = rakam_ascii(b_yil[7:4]);
            5'd3:    bayt_c = rakam_ascii(b_yil[3:0]);
            5'd4:    bayt_c = TIRE;
            5'd5:    bayt_c = rakam_ascii(b_ay[7:4]);
            5'd6:    bayt_c = rakam_ascii(b_ay[3:0]);
            5'd7:    bayt_c = TIRE;
            5'd8:    bayt_c = rakam_ascii(b_gun[7:4]);
            5'd9:    bayt_c = rakam_ascii(b_gun[3:0]);
            5'd10:   bayt_c = BOSLUK;
            5'd11:   bayt_c = rakam_ascii(b_saat[7:4]);
            5'd12:   bayt_c = rakam_ascii(b_saat[3:0]);
            5'd13:   bayt_c = IKI_NOKTA;
            5'd14:   bayt_c = rakam_ascii(b_dakika[7:4]);
            5'd15:   bayt_c = rakam_ascii(b_dakika[3:0]);
            5'd16:   bayt_c = IKI_NOKTA;
            5'd17:   bayt_c = rakam_ascii(b_saniye[7:4]);
            5'd18:   bayt_c = rakam_ascii(b_saniye[3:0]);
            5'd19:   bayt_c = CR;
            default: bayt_c = LF;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            durum        <= BOSTA;
            bekleyen     <= 1'b0;
            indeks       <= '0;
            uart_tx_en   <= 1'b0;
            uart_tx_data <= '0;
            mesgul       <= 1'b0;
            tamamlandi   <= 1'b0;
        end else begin
            durum        <= durum_n;
            bekleyen     <= bekleyen_n;
            indeks       <= indeks_n;
            uart_tx_en   <= uart_tx_en_n;
            uart_tx_data <= uart_tx_data_n;
            mesgul       <= mesgul_n;
            tamamlandi   <= tamamlandi_n;
        end
    end

    // Requests seen mid-frame collapse into one pending flag, served on return to BOSTA.
    always_comb begin
        durum_n        = durum;
        bekleyen_n     = bekleyen | (istek_c & mesgul);
        indeks_n       = indeks;
        uart_tx_en_n   = 1'b0;
        uart_tx_data_n = uart_tx_data;
        tamamlandi_n   = 1'b0;
        yakala_c       = 1'b0;
        case (durum)
            BOSTA: begin
                if (istek_c || bekleyen) begin
                    yakala_c   = 1'b1;
                    bekleyen_n = 1'b0;
                    durum_n    = DONUSTUR;
                end
            end
            DONUSTUR: begin
                indeks_n = '0;
                durum_n  = GONDER;
            end
            GONDER: begin
                if (!uart_tx_busy) begin
                    uart_tx_en_n   = 1'b1;
                    uart_tx_data_n = bayt_c;
                    durum_n        = KORUMA;
                end
            end
            KORUMA: begin
                durum_n = BEKLE;
            end
            BEKLE: begin
                if (!uart_tx_busy) begin
                    if (indeks == SON_INDEKS) begin
                        tamamlandi_n = 1'b1;
                        durum_n      = BOSTA;
                    end else begin
                        indeks_n = indeks + INDEKS_W'(1);
                        durum_n  = GONDER;
                    end
                end
            end
            default: durum_n = BOSTA;
        endcase
        mesgul_n = (durum_n != BOSTA);
    end

endmodule

// File: tb/tb_zaman_raporlayici.sv
// Scoreboard bench for zaman_raporlayici: expected frames are queued at request time,
// a monitor compares every byte strobe and frame completion.
module tb_zaman_raporlayici;

    localparam int unsigned PER = 500;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        baslat = 1'b0;
    logic        periyodik_en = 1'b0;
    logic [4:0]  saat = '0;
    logic [5:0]  dakika = '0;
    logic [5:0]  saniye = '0;
    logic [4:0]  gun = 5'd1;
    logic [3:0]  ay = 4'd1;
    logic [11:0] yil = '0;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        mesgul;
    logic        tamamlandi;

    int tests = 0;
    int fails = 0;
    logic [7:0] bekl_q[$];
    int acik = 0;
    int bayt_say = 0;
    int cerceve_tamam = 0;
    int en_say = 0;
    int cyc = 0;
    int kalan = 0;
    int mesafe = 10;
    int bas_q[$];
    int son_tamam_cyc = 0;

    zaman_raporlayici #(.PERIYOT_CYC(PER)) dut (
        .CLK(CLK), .reset(reset), .baslat(baslat), .periyodik_en(periyodik_en),
        .saat(saat), .dakika(dakika), .saniye(saniye), .gun(gun), .ay(ay), .yil(yil),
        .uart_tx_busy(uart_tx_busy), .uart_tx_en(uart_tx_en), .uart_tx_data(uart_tx_data),
        .mesgul(mesgul), .tamamlandi(tamamlandi)
    );

    always #5 CLK = ~CLK;

    // Transmitter model: busy for 'mesafe' cycles after each accepted byte.
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (uart_tx_en) kalan <= mesafe;
        else if (kalan > 0) kalan <= kalan - 1;
    end
    assign uart_tx_busy = (kalan != 0);

    task automatic kontrol(input string ad, input int gercek, input int beklenen);
        tests++;
        if (gercek != beklenen) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", ad, gercek, beklenen);
        end
    endtask

    function automatic void iki_hane(input int v);
        bekl_q.push_back(8'(48 + (v % 100) / 10));
        bekl_q.push_back(8'(48 + v % 10));
    endfunction

    function automatic void cerceve_ekle();
        int y;
        y = int'(yil);
        bekl_q.push_back(8'(48 + (y / 1000) % 10));
        bekl_q.push_back(8'(48 + (y / 100) % 10));
        bekl_q.push_back(8'(48 + (y / 10) % 10));
        bekl_q.push_back(8'(48 + y % 10));
        bekl_q.push_back(8'h2D);
        iki_hane(int'(ay));
        bekl_q.push_back(8'h2D);
        iki_hane(int'(gun));
        bekl_q.push_back(8'h20);
        iki_hane(int'(saat));
        bekl_q.push_back(8'h3A);
        iki_hane(int'(dakika));
        bekl_q.push_back(8'h3A);
        iki_hane(int'(saniye));
        bekl_q.push_back(8'h0D);
        bekl_q.push_back(8'h0A);
    endfunction

    // One frame in flight plus at most one pending; further requests merge.
    function automatic void istek_model();
        if (acik < 2) begin
            cerceve_ekle();
            acik++;
        end
    endfunction

    initial begin
        forever begin
            @(negedge CLK);
            if (uart_tx_en) begin
                en_say++;
                if (bayt_say == 0) bas_q.push_back(cyc);
                if (bekl_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_byte: got %0d expected none", uart_tx_data);
                end else begin
                    kontrol($sformatf("byte%0d", bayt_say), int'(uart_tx_data), int'(bekl_q.pop_front()));
                end
                bayt_say++;
            end
            if (tamamlandi) begin
                kontrol("frame_len", bayt_say, 21);
                bayt_say = 0;
                if (acik == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got 1 expected 0");
                end else begin
                    acik--;
                end
                cerceve_tamam++;
                son_tamam_cyc = cyc;
            end
        end
    end

    task automatic bas_ver();
        baslat = 1'b1;
        istek_model();
        @(negedge CLK);
        baslat = 1'b0;
    endtask

    task automatic bos_bekle(input int sinir);
        int k = 0;
        while ((acik != 0 || mesgul) && k < sinir) begin
            @(negedge CLK);
            k++;
        end
        kontrol("drain_timeout", acik, 0);
        repeat (3) @(negedge CLK);
    endtask

    task automatic bayt_bekle(input int n);
        int k = 0;
        while (bayt_say < n && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        kontrol("byte_wait", int'(bayt_say >= n), 1);
    endtask

    task automatic zaman_ayarla(input int y, input int a, input int g, input int s, input int d, input int sn);
        yil = 12'(y); ay = 4'(a); gun = 5'(g); saat = 5'(s); dakika = 6'(d); saniye = 6'(sn);
    endtask

    initial begin
        int k, en0, t0, t1, c0;
        repeat (3) @(negedge CLK);
        kontrol("rst_en", int'(uart_tx_en), 0);
        kontrol("rst_data", int'(uart_tx_data), 0);
        kontrol("rst_mesgul", int'(mesgul), 0);
        kontrol("rst_done", int'(tamamlandi), 0);
        reset = 1'b0;
        repeat (2) @(negedge CLK);

        // Nominal frame, with first-byte latency.
        zaman_ayarla(2024, 7, 30, 18, 30, 5);
        en0 = en_say;
        c0  = cerceve_tamam;
        baslat = 1'b1;
        istek_model();
        @(negedge CLK);
        baslat = 1'b0;
        k = 1;
        while (!uart_tx_en && k < 10) begin
            @(negedge CLK);
            k++;
        end
        kontrol("latency", k, 3);
        kontrol("mesgul_active", int'(mesgul), 1);
        bos_bekle(2000);
        kontrol("en_pulses", en_say - en0, 21);
        kontrol("done_pulses", cerceve_tamam - c0, 1);

        // Leading zeros and out-of-range fields.
        zaman_ayarla(7, 1, 1, 0, 0, 9);
        bas_ver();
        bos_bekle(2000);
        zaman_ayarla(4095, 15, 31, 27, 63, 63);
        bas_ver();
        bos_bekle(2000);

        // Inputs changed mid-frame must not leak into the frame.
        zaman_ayarla(2024, 7, 30, 18, 30, 5);
        bas_ver();
        bayt_bekle(5);
        saat = 5'd19;
        dakika = 6'($urandom_range(0, 63));
        yil = 12'($urandom);
        bos_bekle(2000);

        // Three mid-frame requests collapse into one follow-up frame.
        zaman_ayarla(1999, 12, 31, 23, 59, 58);
        c0 = cerceve_tamam;
        bas_ver();
        bayt_bekle(3);
        bas_ver();
        bayt_bekle(8);
        bas_ver();
        bayt_bekle(12);
        bas_ver();
        k = 0;
        while (cerceve_tamam < c0 + 1 && k < 3000) begin
            @(negedge CLK);
            k++;
        end
        t1 = son_tamam_cyc;
        bos_bekle(3000);
        kontrol("coalesced_frames", cerceve_tamam - c0, 2);
        kontrol("pending_gap", bas_q[bas_q.size()-1] - t1, 3);

        // Randomized frames with varying transmitter busy length.
        for (int i = 0; i < 8; i++) begin
            zaman_ayarla(int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
                         int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
                         int'($urandom_range(0, 63)), int'($urandom_range(0, 63)));
            mesafe = int'($urandom_range(0, 12));
            bas_ver();
            bos_bekle(3000);
        end

        // Periodic mode with a fast transmitter.
        mesafe = 1;
        zaman_ayarla(2030, 2, 14, 6, 45, 0);
        bas_q.delete();
        for (int i = 0; i < 3; i++) cerceve_ekle();
        acik += 3;
        periyodik_en = 1'b1;
        t0 = cyc;
        k = 0;
        while (bas_q.size() < 3 && k < 2000) begin
            @(negedge CLK);
            k++;
        end
        kontrol("periodic_starts", int'(bas_q.size()), 3);
        if (bas_q.size() >= 3) begin
            kontrol("periodic_first", bas_q[0] - t0, PER + 2);
            kontrol("periodic_gap1", bas_q[1] - bas_q[0], PER);
            kontrol("periodic_gap2", bas_q[2] - bas_q[1], PER);
        end
        periyodik_en = 1'b0;
        bos_bekle(1000);
        repeat (1200) @(negedge CLK);
        kontrol("periodic_stopped", int'(bas_q.size()), 3);
        cerceve_ekle();
        acik++;
        periyodik_en = 1'b1;
        t0 = cyc;
        k = 0;
        while (bas_q.size() < 4 && k < 1000) begin
            @(negedge CLK);
            k++;
        end
        periyodik_en = 1'b0;
        kontrol("periodic_restart", int'(bas_q.size()), 4);
        if (bas_q.size() >= 4) kontrol("periodic_restart_lat", bas_q[3] - t0, PER + 2);
        bos_bekle(1000);

        // Reset in the middle of a frame.
        mesafe = 10;
        zaman_ayarla(2012, 3, 4, 5, 6, 7);
        bas_ver();
        bayt_bekle(11);
        @(negedge CLK);
        reset = 1'b1;
        bekl_q.delete();
        acik = 0;
        bayt_say = 0;
        @(negedge CLK);
        kontrol("midrst_en", int'(uart_tx_en), 0);
        kontrol("midrst_mesgul", int'(mesgul), 0);
        reset = 1'b0;
        c0 = cerceve_tamam;
        repeat (300) @(negedge CLK);
        kontrol("midrst_no_done", cerceve_tamam - c0, 0);
        en0 = en_say;
        bas_ver();
        bos_bekle(2000);
        kontrol("post_rst_bytes", en_say - en0, 21);
        kontrol("post_rst_done", cerceve_tamam - c0, 1);

        kontrol("queue_empty", int'(bekl_q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
